// File: rtl/lsq_v2_if.sv
// Load/store queue bundle: dispatch allocation, ROB commit/flush, scratchpad bus, CDB and occupancy.
interface lsq_v2_if #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 8,
  parameter int SQ_DEPTH = 8,
  parameter int TAG_W    = 6
);
  logic                          alloc_valid;
  logic                          alloc_ready;
  logic                          alloc_is_load;
  logic [1:0]                    alloc_size;
  logic [XLEN-1:0]               alloc_addr;
  logic [XLEN-1:0]               alloc_wdata;
  logic [TAG_W-1:0]              alloc_tag;
  logic                          commit_store;
  logic                          flush;
  logic                          mem_req_valid;
  logic                          mem_req_ready;
  logic                          mem_we;
  logic [XLEN-1:0]               mem_addr;
  logic [XLEN-1:0]               mem_wdata;
  logic [XLEN/8-1:0]             mem_be;
  logic                          mem_rsp_valid;
  logic [XLEN-1:0]               mem_rdata;
  logic                          mem_rsp_err;
  logic                          cdb_valid;
  logic [TAG_W-1:0]              cdb_tag;
  logic [XLEN-1:0]               cdb_data;
  logic                          cdb_exc;
  logic [$clog2(LQ_DEPTH):0]     lq_count;
  logic [$clog2(SQ_DEPTH):0]     sq_count;

  modport slave (
    input  alloc_valid, alloc_is_load, alloc_size, alloc_addr, alloc_wdata, alloc_tag,
    input  commit_store, flush, mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    output alloc_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    output cdb_valid, cdb_tag, cdb_data, cdb_exc, lq_count, sq_count
  );

  modport master (
    output alloc_valid, alloc_is_load, alloc_size, alloc_addr, alloc_wdata, alloc_tag,
    output commit_store, flush, mem_req_ready, mem_rsp_valid, mem_rdata, mem_rsp_err,
    input  alloc_ready, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_be,
    input  cdb_valid, cdb_tag, cdb_data, cdb_exc, lq_count, sq_count
  );
endinterface

// File: rtl/lsq_v2.sv
// In-order load/store queue with byte-enable accesses, store-to-load forwarding,
// committed-store drain and branch flush over a single-outstanding scratchpad bus.
module lsq_v2 #(
  parameter int XLEN     = 32,
  parameter int LQ_DEPTH = 8,
  parameter int SQ_DEPTH = 8,
  parameter int TAG_W    = 6
) (
  input  logic    clk,
  input  logic    reset,
  lsq_v2_if.slave bus
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  localparam int LA = $clog2(LQ_DEPTH);
  localparam int SA = $clog2(SQ_DEPTH);

  typedef enum logic [2:0] {S_IDLE, S_ST_REQ, S_ST_RSP, S_LD_REQ, S_LD_RSP} state_t;

  function automatic logic [NB-1:0] lane_be(input logic [1:0] size, input logic [OW-1:0] off);
    logic [2*NB-1:0] m;
    case (size)
      2'd0:    m = (2*NB)'(1);
      2'd1:    m = (2*NB)'(3);
      default: m = (2*NB)'(15);
    endcase
    m = m << off;
    return m[NB-1:0];
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    return (size == 2'd3) || (size == 2'd1 && lo[0]) || (size == 2'd2 && lo != 2'b00);
  endfunction

  // Shift the addressed lane down and zero-extend to the access size.
  function automatic logic [XLEN-1:0] lane_extract(input logic [XLEN-1:0] data,
                                                   input logic [1:0] size,
                                                   input logic [OW-1:0] off);
    logic [XLEN-1:0] sh;
    sh = data >> {off, 3'b000};
    case (size)
      2'd0:    return XLEN'(sh[7:0]);
      2'd1:    return XLEN'(sh[15:0]);
      default: return XLEN'(sh[31:0]);
    endcase
  endfunction

  state_t state_q, state_d;
  logic [LA:0] lq_head_q, lq_head_d, lq_tail_q, lq_tail_d;
  logic [SA:0] sq_head_q, sq_head_d, sq_tail_q, sq_tail_d, sq_cmt_q, sq_cmt_d;
  logic        mem_req_valid_q, mem_req_valid_d, mem_we_q, mem_we_d;
  logic        cdb_valid_q, cdb_valid_d, cdb_exc_q, cdb_exc_d, ld_kill_q, ld_kill_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d, cdb_data_q, cdb_data_d;
  logic [NB-1:0]    mem_be_q, mem_be_d;
  logic [TAG_W-1:0] cdb_tag_q, cdb_tag_d;

  logic [XLEN-1:0]  lq_addr_q [LQ_DEPTH];
  logic [1:0]       lq_size_q [LQ_DEPTH];
  logic [TAG_W-1:0] lq_tag_q  [LQ_DEPTH];
  logic             lq_exc_q  [LQ_DEPTH];
  logic [SA:0]      lq_fence_q[LQ_DEPTH];
  logic [XLEN-1:0]  sq_addr_q [SQ_DEPTH];
  logic [1:0]       sq_size_q [SQ_DEPTH];
  logic [XLEN-1:0]  sq_data_q [SQ_DEPTH];
  logic             sq_exc_q  [SQ_DEPTH];

  logic lq_full, sq_full, alloc_fire, lq_push, sq_push;
  logic [LA-1:0] lh;
  logic [SA-1:0] sh, fwd_idx;
  logic [SA:0]   older, fwd_ptr;
  logic [NB-1:0] ld_be, fwd_be;
  logic          fwd_hit, fwd_full;
  logic [XLEN-1:0] fwd_data;

  assign lq_full         = (lq_tail_q - lq_head_q) == (LA+1)'(LQ_DEPTH);
  assign sq_full         = (sq_tail_q - sq_head_q) == (SA+1)'(SQ_DEPTH);
  assign bus.alloc_ready = bus.alloc_is_load ? !lq_full : !sq_full;
  assign alloc_fire      = bus.alloc_valid && bus.alloc_ready && !bus.flush;
  assign lq_push         = alloc_fire && bus.alloc_is_load;
  assign sq_push         = alloc_fire && !bus.alloc_is_load;
  assign lh              = lq_head_q[LA-1:0];
  assign sh              = sq_head_q[SA-1:0];

  // Youngest older store to the same word with any byte overlap decides forwarding.
  always_comb begin
    ld_be   = lane_be(lq_size_q[lh], lq_addr_q[lh][OW-1:0]);
    older   = lq_fence_q[lh] - sq_head_q;
    fwd_hit = 1'b0;
    fwd_idx = '0;
    fwd_ptr = '0;
    if (older > (SA+1)'(SQ_DEPTH)) older = '0;
    for (int k = 0; k < SQ_DEPTH; k++) begin
      fwd_ptr = sq_head_q + (SA+1)'(k);
      if ((SA+1)'(k) < older && !sq_exc_q[fwd_ptr[SA-1:0]] &&
          sq_addr_q[fwd_ptr[SA-1:0]][XLEN-1:OW] == lq_addr_q[lh][XLEN-1:OW] &&
          (lane_be(sq_size_q[fwd_ptr[SA-1:0]], sq_addr_q[fwd_ptr[SA-1:0]][OW-1:0]) & ld_be) != '0) begin
        fwd_hit = 1'b1;
        fwd_idx = fwd_ptr[SA-1:0];
      end
    end
    fwd_be   = lane_be(sq_size_q[fwd_idx], sq_addr_q[fwd_idx][OW-1:0]);
    fwd_full = fwd_hit && ((ld_be & ~fwd_be) == '0);
    fwd_data = lane_extract(lane_extract(sq_data_q[fwd_idx], sq_size_q[fwd_idx], '0)
                              << {sq_addr_q[fwd_idx][OW-1:0], 3'b000},
                            lq_size_q[lh], lq_addr_q[lh][OW-1:0]);
  end

  always_comb begin
    state_d         = state_q;
    lq_head_d       = lq_head_q;
    lq_tail_d       = lq_tail_q + (lq_push ? (LA+1)'(1) : '0);
    sq_head_d       = sq_head_q;
    sq_tail_d       = sq_tail_q + (sq_push ? (SA+1)'(1) : '0);
    sq_cmt_d        = sq_cmt_q;
    mem_req_valid_d = mem_req_valid_q;
    mem_we_d        = mem_we_q;
    mem_addr_d      = mem_addr_q;
    mem_wdata_d     = mem_wdata_q;
    mem_be_d        = mem_be_q;
    cdb_valid_d     = 1'b0;
    cdb_exc_d       = 1'b0;
    cdb_tag_d       = cdb_tag_q;
    cdb_data_d      = cdb_data_q;
    ld_kill_d       = ld_kill_q;
    if (bus.commit_store && sq_cmt_q != sq_tail_q) sq_cmt_d = sq_cmt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        if (sq_head_q != sq_cmt_q) begin
          if (sq_exc_q[sh]) begin
            sq_head_d = sq_head_q + 1'b1;
          end else begin
            state_d         = S_ST_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b1;
            mem_addr_d      = {sq_addr_q[sh][XLEN-1:OW], {OW{1'b0}}};
            mem_wdata_d     = lane_extract(sq_data_q[sh], sq_size_q[sh], '0)
                                << {sq_addr_q[sh][OW-1:0], 3'b000};
            mem_be_d        = lane_be(sq_size_q[sh], sq_addr_q[sh][OW-1:0]);
          end
        end else if (lq_head_q != lq_tail_q && !bus.flush) begin
          cdb_tag_d = lq_tag_q[lh];
          if (lq_exc_q[lh]) begin
            cdb_valid_d = 1'b1;
            cdb_exc_d   = 1'b1;
            cdb_data_d  = '0;
            lq_head_d   = lq_head_q + 1'b1;
          end else if (fwd_full) begin
            cdb_valid_d = 1'b1;
            cdb_data_d  = fwd_data;
            lq_head_d   = lq_head_q + 1'b1;
          end else if (!fwd_hit) begin
            state_d         = S_LD_REQ;
            mem_req_valid_d = 1'b1;
            mem_we_d        = 1'b0;
            mem_addr_d      = {lq_addr_q[lh][XLEN-1:OW], {OW{1'b0}}};
            mem_be_d        = ld_be;
            ld_kill_d       = 1'b0;
          end
        end
      end
      S_ST_REQ, S_LD_REQ: begin
        if (bus.mem_req_ready) begin
          mem_req_valid_d = 1'b0;
          state_d         = (state_q == S_ST_REQ) ? S_ST_RSP : S_LD_RSP;
        end
      end
      S_ST_RSP: begin
        if (bus.mem_rsp_valid) begin
          sq_head_d = sq_head_q + 1'b1;
          state_d   = S_IDLE;
        end
      end
      S_LD_RSP: begin
        if (bus.mem_rsp_valid) begin
          state_d = S_IDLE;
          if (!ld_kill_q && !bus.flush) begin
            cdb_valid_d = 1'b1;
            cdb_tag_d   = lq_tag_q[lh];
            cdb_exc_d   = bus.mem_rsp_err;
            cdb_data_d  = bus.mem_rsp_err ? '0 :
                          lane_extract(bus.mem_rdata, lq_size_q[lh], lq_addr_q[lh][OW-1:0]);
            lq_head_d   = lq_head_q + 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Flush: the in-flight load still finishes on the bus, but its result is dropped.
    if (bus.flush) begin
      lq_tail_d = lq_head_d;
      sq_tail_d = sq_cmt_d;
      if (state_q == S_LD_REQ || state_q == S_LD_RSP) ld_kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      lq_head_q       <= '0;
      lq_tail_q       <= '0;
      sq_head_q       <= '0;
      sq_tail_q       <= '0;
      sq_cmt_q        <= '0;
      mem_req_valid_q <= 1'b0;
      mem_we_q        <= 1'b0;
      cdb_valid_q     <= 1'b0;
      cdb_exc_q       <= 1'b0;
      ld_kill_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      lq_head_q       <= lq_head_d;
      lq_tail_q       <= lq_tail_d;
      sq_head_q       <= sq_head_d;
      sq_tail_q       <= sq_tail_d;
      sq_cmt_q        <= sq_cmt_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_we_q        <= mem_we_d;
      cdb_valid_q     <= cdb_valid_d;
      cdb_exc_q       <= cdb_exc_d;
      ld_kill_q       <= ld_kill_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_addr_q  <= mem_addr_d;
    mem_wdata_q <= mem_wdata_d;
    mem_be_q    <= mem_be_d;
    cdb_tag_q   <= cdb_tag_d;
    cdb_data_q  <= cdb_data_d;
    if (lq_push) begin
      lq_addr_q[lq_tail_q[LA-1:0]]  <= bus.alloc_addr;
      lq_size_q[lq_tail_q[LA-1:0]]  <= bus.alloc_size;
      lq_tag_q[lq_tail_q[LA-1:0]]   <= bus.alloc_tag;
      lq_exc_q[lq_tail_q[LA-1:0]]   <= misaligned(bus.alloc_size, bus.alloc_addr[1:0]);
      lq_fence_q[lq_tail_q[LA-1:0]] <= sq_tail_q;
    end
    if (sq_push) begin
      sq_addr_q[sq_tail_q[SA-1:0]] <= bus.alloc_addr;
      sq_size_q[sq_tail_q[SA-1:0]] <= bus.alloc_size;
      sq_data_q[sq_tail_q[SA-1:0]] <= bus.alloc_wdata;
      sq_exc_q[sq_tail_q[SA-1:0]]  <= misaligned(bus.alloc_size, bus.alloc_addr[1:0]);
    end
  end

  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.mem_be        = mem_be_q;
  assign bus.cdb_valid     = cdb_valid_q;
  assign bus.cdb_tag       = cdb_tag_q;
  assign bus.cdb_data      = cdb_data_q;
  assign bus.cdb_exc       = cdb_exc_q;
  assign bus.lq_count      = lq_tail_q - lq_head_q;
  assign bus.sq_count      = sq_tail_q - sq_head_q;
endmodule
